// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx_pkg
// Description : Shared PS/2 definitions. This package holds the controller
//               state encoding, the default timing constants and the parity
//               helper. It is usable by both the host transmitter and the
//               receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_host_tx_pkg;

    // Default timing at 50 MHz: a 120 us clock inhibit, and a 20 ms limit
    // from clock release to the device acknowledge.
    localparam int c_INHIBIT_CYCLES_DEFAULT = 6000;
    localparam int c_TIMEOUT_CYCLES_DEFAULT = 1000000;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_INHIBIT   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_REQ       = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_SEND      = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_ACK       = 3'd4;
    localparam logic [c_STATE_W-1:0] c_ST_WAIT_IDLE = 3'd5;

    // The PS/2 frame carries odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Three-flop synchronizer for one asynchronous PS/2 line. It
//               produces the synchronized level and a one-cycle pulse on a
//               falling edge. The chain resets to 1, which is the
//               released-bus level.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic [2:0] r_sync;

    // Shift the raw line level through the chain. Bit 0 is the newest sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b111;
        end else begin
            r_sync <= {r_sync[1:0], i_line};
        end
    end

    assign o_level = r_sync[2];
    assign o_fall  = r_sync[2] & ~r_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter. The block inhibits
//               the clock, issues the request-to-send, shifts out the data,
//               parity and stop bits on the device clock, and then checks the
//               acknowledge. It reports the result with tx_done or tx_error.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = c_INHIBIT_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int c_INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic w_clk_level, w_clk_fall, w_data_level, w_data_fall;

    logic [c_STATE_W-1:0] r_state, w_state_nxt;
    logic                 r_clk_oe, w_clk_oe_nxt;
    logic                 r_data_oe, w_data_oe_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_error, w_error_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic                 r_parity, w_parity_nxt;
    logic [c_INH_W-1:0]   r_inh_cnt, w_inh_cnt_nxt;
    logic [3:0]           r_edge_cnt, w_edge_cnt_nxt;
    logic [c_TO_W-1:0]    r_to_cnt, w_to_cnt_nxt;
    logic                 w_timing;
    logic                 w_bus_idle;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (ps2_clk_in),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (ps2_data_in),
        .o_level (w_data_level),
        .o_fall  (w_data_fall)
    );

    // The bus counts as idle when both lines are high and neither has just
    // started to fall.
    assign w_bus_idle = w_clk_level & w_data_level & ~w_clk_fall & ~w_data_fall;

    // Next-state and next-output logic. Every output is registered, so this
    // logic computes the value the outputs take in the following cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_clk_oe_nxt   = r_clk_oe;
        w_data_oe_nxt  = r_data_oe;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;
        w_data_nxt     = r_data;
        w_parity_nxt   = r_parity;
        w_inh_cnt_nxt  = r_inh_cnt;
        w_edge_cnt_nxt = r_edge_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_timing       = (r_state == c_ST_SEND) || (r_state == c_ST_ACK) ||
                         (r_state == c_ST_WAIT_IDLE);

        if (w_timing) begin
            w_to_cnt_nxt = r_to_cnt + c_TO_W'(1);
        end

        case (r_state)
            c_ST_IDLE: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                if (tx_valid && r_ready) begin
                    w_data_nxt    = tx_data;
                    w_parity_nxt  = odd_parity(tx_data);
                    w_inh_cnt_nxt = '0;
                    w_clk_oe_nxt  = 1'b1;
                    w_state_nxt   = c_ST_INHIBIT;
                end
            end
            c_ST_INHIBIT: begin
                if (r_inh_cnt == c_INH_LAST) begin
                    w_data_oe_nxt = 1'b1;
                    w_state_nxt   = c_ST_REQ;
                end else begin
                    w_inh_cnt_nxt = r_inh_cnt + c_INH_W'(1);
                end
            end
            c_ST_REQ: begin
                // The start bit is already driven. Releasing the clock
                // hands control of the clock to the device.
                w_clk_oe_nxt   = 1'b0;
                w_edge_cnt_nxt = '0;
                w_to_cnt_nxt   = '0;
                w_state_nxt    = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_clk_fall) begin
                    w_edge_cnt_nxt = r_edge_cnt + 4'd1;
                    if (r_edge_cnt < 4'd8) begin
                        w_data_oe_nxt = ~r_data[r_edge_cnt[2:0]];
                    end else if (r_edge_cnt == 4'd8) begin
                        w_data_oe_nxt = ~r_parity;
                    end else begin
                        w_data_oe_nxt = 1'b0;
                        w_state_nxt   = c_ST_ACK;
                    end
                end
            end
            c_ST_ACK: begin
                if (w_clk_fall) begin
                    if (!w_data_level) begin
                        w_state_nxt = c_ST_WAIT_IDLE;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_WAIT_IDLE: begin
                if (w_bus_idle) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_clk_oe_nxt  = 1'b0;
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = c_ST_IDLE;
            end
        endcase

        // An expired timeout overrides every other outcome. This keeps done
        // and error mutually exclusive.
        if (w_timing && (r_to_cnt == c_TO_LAST)) begin
            w_clk_oe_nxt  = 1'b0;
            w_data_oe_nxt = 1'b0;
            w_done_nxt    = 1'b0;
            w_error_nxt   = 1'b1;
            w_state_nxt   = c_ST_IDLE;
        end

        w_ready_nxt = (w_state_nxt == c_ST_IDLE);
    end

    // State, output and datapath registers. The reset releases both lines
    // asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_data     <= '0;
            r_parity   <= 1'b0;
            r_inh_cnt  <= '0;
            r_edge_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_ready    <= w_ready_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_data     <= w_data_nxt;
            r_parity   <= w_parity_nxt;
            r_inh_cnt  <= w_inh_cnt_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_ready    = r_ready;
    assign tx_done     = r_done;
    assign tx_error    = r_error;

endmodule
`default_nettype wire
